// File: rtl/cmult_rr_sched.sv
// cmult_rr_sched
// Round-robin front end for one shared, fully pipelined complex multiplier.
// Each cycle at most one requesting channel is granted, and its operands are
// registered into the multiplier. The channel index travels down a tag pipe
// that matches the multiplier latency, so every result comes back tagged.
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   s_din{1,2}_{re,im}    : per-channel operands, channel i at [i*W +: W]
//   s_valid / s_ready     : per-channel request / one-hot grant (combinational)
//   m_din{1,2}_{re,im}    : registered operands to the multiplier
//   m_din_valid           : issue strobe to the multiplier
//   m_dout_{re,im,valid}  : multiplier result
//   dout_{re,im,ch,valid} : registered, channel-tagged result
//   tag_err               : sticky result/tag mismatch flag
module cmult_rr_sched #(
  parameter int N_CH         = 4,
  parameter int DIN1_WIDTH   = 16,
  parameter int DIN2_WIDTH   = 16,
  parameter int MULT_LATENCY = 6,
  localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int DOUT_W      = DIN1_WIDTH + DIN2_WIDTH + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_CH*DIN1_WIDTH-1:0] s_din1_re,
  input  logic [N_CH*DIN1_WIDTH-1:0] s_din1_im,
  input  logic [N_CH*DIN2_WIDTH-1:0] s_din2_re,
  input  logic [N_CH*DIN2_WIDTH-1:0] s_din2_im,
  input  logic [N_CH-1:0]            s_valid,
  output logic [N_CH-1:0]            s_ready,
  output logic [DIN1_WIDTH-1:0]      m_din1_re,
  output logic [DIN1_WIDTH-1:0]      m_din1_im,
  output logic [DIN2_WIDTH-1:0]      m_din2_re,
  output logic [DIN2_WIDTH-1:0]      m_din2_im,
  output logic                       m_din_valid,
  input  logic [DOUT_W-1:0]          m_dout_re,
  input  logic [DOUT_W-1:0]          m_dout_im,
  input  logic                       m_dout_valid,
  output logic [DOUT_W-1:0]          dout_re,
  output logic [DOUT_W-1:0]          dout_im,
  output logic [CH_W-1:0]            dout_ch,
  output logic                       dout_valid,
  output logic                       tag_err
);

  localparam int FC_W = $clog2(MULT_LATENCY + 1);

  // per-channel operand views
  logic [DIN1_WIDTH-1:0] d1_re [N_CH];
  logic [DIN1_WIDTH-1:0] d1_im [N_CH];
  logic [DIN2_WIDTH-1:0] d2_re [N_CH];
  logic [DIN2_WIDTH-1:0] d2_im [N_CH];

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign d1_re[g] = s_din1_re[g*DIN1_WIDTH +: DIN1_WIDTH];
    assign d1_im[g] = s_din1_im[g*DIN1_WIDTH +: DIN1_WIDTH];
    assign d2_re[g] = s_din2_re[g*DIN2_WIDTH +: DIN2_WIDTH];
    assign d2_im[g] = s_din2_im[g*DIN2_WIDTH +: DIN2_WIDTH];
  end

  logic [CH_W-1:0]  last;
  logic [CH_W-1:0]  gnt_idx;
  logic [CH_W-1:0]  cand_idx;
  logic             gnt_any;
  logic             xfer;
  logic [FC_W-1:0]  flush_cnt;
  logic             flush;
  int               cand;

  // Flush window: covers results of ops issued before reset that are still
  // inside the multiplier, which has no reset of its own.
  assign flush = (flush_cnt != '0);

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= N_CH; k++) begin
      cand = int'(last) + k;
      if (cand >= N_CH) cand = cand - N_CH;
      cand_idx = CH_W'(cand);
      if (!gnt_any && s_valid[cand_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = cand_idx;
      end
    end
    xfer    = gnt_any && !flush && !rst;
    s_ready = '0;
    if (xfer) s_ready[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt <= FC_W'(MULT_LATENCY);
      last      <= CH_W'(N_CH - 1);
    end else begin
      if (flush) flush_cnt <= flush_cnt - 1'b1;
      if (xfer)  last      <= gnt_idx;
    end
  end

  // Issue register
  always_ff @(posedge clk) begin
    if (rst) begin
      m_din1_re   <= '0;
      m_din1_im   <= '0;
      m_din2_re   <= '0;
      m_din2_im   <= '0;
      m_din_valid <= 1'b0;
    end else begin
      m_din_valid <= xfer;
      if (xfer) begin
        m_din1_re <= d1_re[gnt_idx];
        m_din1_im <= d1_im[gnt_idx];
        m_din2_re <= d2_re[gnt_idx];
        m_din2_im <= d2_im[gnt_idx];
      end
    end
  end

  // Tag pipe: stage 0 is aligned with m_din_valid, so stage MULT_LATENCY is
  // aligned with m_dout_valid.
  logic [MULT_LATENCY:0] vld_pipe;
  logic [CH_W-1:0]       ch_pipe [MULT_LATENCY+1];
  logic                  tag_hit;

  always_ff @(posedge clk) begin
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[MULT_LATENCY-1:0], xfer};
  end

  always_ff @(posedge clk) begin
    ch_pipe[0] <= gnt_idx;
    for (int i = 1; i <= MULT_LATENCY; i++) ch_pipe[i] <= ch_pipe[i-1];
  end

  assign tag_hit = vld_pipe[MULT_LATENCY];

  // Result stage
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_re    <= '0;
      dout_im    <= '0;
      dout_ch    <= '0;
      dout_valid <= 1'b0;
      tag_err    <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (!flush && m_dout_valid && tag_hit) begin
        dout_re    <= m_dout_re;
        dout_im    <= m_dout_im;
        dout_ch    <= ch_pipe[MULT_LATENCY];
        dout_valid <= 1'b1;
      end
      if (!flush && (m_dout_valid ^ tag_hit)) tag_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cmult_rr_sched.sv
module tb_cmult_rr_sched;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int OW = 33;
  localparam int LAT = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic [N*W-1:0]    s_din1_re, s_din1_im, s_din2_re, s_din2_im;
  logic [N-1:0]      s_valid, s_ready;
  logic [W-1:0]      m_din1_re, m_din1_im, m_din2_re, m_din2_im;
  logic              m_din_valid;
  logic [OW-1:0]     m_dout_re, m_dout_im;
  logic              m_dout_valid;
  logic [OW-1:0]     dout_re, dout_im;
  logic [1:0]        dout_ch;
  logic              dout_valid, tag_err;
  logic              inj = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cmult_rr_sched #(.N_CH(N), .DIN1_WIDTH(W), .DIN2_WIDTH(W), .MULT_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .s_din1_re(s_din1_re), .s_din1_im(s_din1_im),
    .s_din2_re(s_din2_re), .s_din2_im(s_din2_im),
    .s_valid(s_valid), .s_ready(s_ready),
    .m_din1_re(m_din1_re), .m_din1_im(m_din1_im),
    .m_din2_re(m_din2_re), .m_din2_im(m_din2_im),
    .m_din_valid(m_din_valid),
    .m_dout_re(m_dout_re), .m_dout_im(m_dout_im), .m_dout_valid(m_dout_valid),
    .dout_re(dout_re), .dout_im(dout_im), .dout_ch(dout_ch),
    .dout_valid(dout_valid), .tag_err(tag_err)
  );

  // complex multiplier model, 6-cycle latency, no reset
  logic signed [OW-1:0] ar, ai, br, bi, mre, mim;
  logic signed [OW-1:0] pr [LAT];
  logic signed [OW-1:0] pi [LAT];
  logic [LAT-1:0]       pv = '0;

  assign ar  = OW'($signed(m_din1_re));
  assign ai  = OW'($signed(m_din1_im));
  assign br  = OW'($signed(m_din2_re));
  assign bi  = OW'($signed(m_din2_im));
  assign mre = ar * br - ai * bi;
  assign mim = ar * bi + ai * br;

  always @(posedge clk) begin
    pv    <= {pv[LAT-2:0], m_din_valid};
    pr[0] <= mre;
    pi[0] <= mim;
    for (int i = 1; i < LAT; i++) begin
      pr[i] <= pr[i-1];
      pi[i] <= pi[i-1];
    end
  end

  assign m_dout_re    = pr[LAT-1];
  assign m_dout_im    = pi[LAT-1];
  assign m_dout_valid = pv[LAT-1] | inj;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // expected results scoreboard
  typedef struct {
    int     ch;
    longint re;
    longint im;
    int     cyc;
  } exp_t;
  exp_t expq[$];

  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0 && expq[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_dout: got none expected ch %0d at cycle %0d", expq[0].ch, expq[0].cyc);
      void'(expq.pop_front());
    end
    if (dout_valid) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_dout: got ch %0d at cycle %0d expected no result", dout_ch, cyc);
      end else begin
        e = expq.pop_front();
        chk("dout_cycle", cyc, e.cyc);
        chk("dout_ch", dout_ch, e.ch);
        chk("dout_re", $signed(dout_re), e.re);
        chk("dout_im", $signed(dout_im), e.im);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // operand set for stimulus row r: ch i gets din1=(i+1+r, -(i+2)), din2=(r-3, 3i+1)
  task automatic set_ops(input int r);
    for (int i = 0; i < N; i++) begin
      s_din1_re[i*W +: W] = W'(i + 1 + r);
      s_din1_im[i*W +: W] = W'(-(i + 2));
      s_din2_re[i*W +: W] = W'(r - 3);
      s_din2_im[i*W +: W] = W'(3 * i + 1);
    end
  endtask

  task automatic push_exp(input int ch, input int r);
    exp_t   e;
    longint a_r, a_i, b_r, b_i;
    a_r = ch + 1 + r;
    a_i = -(ch + 2);
    b_r = r - 3;
    b_i = 3 * ch + 1;
    e.ch  = ch;
    e.re  = a_r * b_r - a_i * b_i;
    e.im  = a_r * b_i + a_i * b_r;
    e.cyc = cyc + 8;
    expq.push_back(e);
  endtask

  typedef struct {
    logic [N-1:0] valid;
    logic [N-1:0] ready;
    int           ch;
  } vec_t;
  vec_t tbl [16];

  initial begin
    exp_t e1;
    // starts with last = 2 (after the single-request test)
    tbl[0]  = '{4'hF, 4'h8, 3};
    tbl[1]  = '{4'hF, 4'h1, 0};   // wrap 3 -> 0
    tbl[2]  = '{4'hF, 4'h2, 1};
    tbl[3]  = '{4'hF, 4'h4, 2};
    tbl[4]  = '{4'h0, 4'h0, -1};
    tbl[5]  = '{4'hA, 4'h8, 3};   // channels 1 and 3 alternate
    tbl[6]  = '{4'hA, 4'h2, 1};
    tbl[7]  = '{4'hA, 4'h8, 3};
    tbl[8]  = '{4'h1, 4'h1, 0};   // lone requester every cycle
    tbl[9]  = '{4'h1, 4'h1, 0};
    tbl[10] = '{4'h1, 4'h1, 0};
    tbl[11] = '{4'h9, 4'h8, 3};
    tbl[12] = '{4'h9, 4'h1, 0};
    tbl[13] = '{4'h6, 4'h2, 1};
    tbl[14] = '{4'h6, 4'h4, 2};
    tbl[15] = '{4'h6, 4'h2, 1};

    rst = 1'b1;
    s_valid = '1;
    set_ops(0);
    tick();
    tick();

    // reset state
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_din_valid", m_din_valid, 0);
    chk("rst_m_din1_re", m_din1_re, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_dout_ch", dout_ch, 0);
    chk("rst_dout_re", dout_re, 0);
    chk("rst_tag_err", tag_err, 0);

    // flush window: no grants for 6 cycles
    rst = 1'b0;
    for (int k = 0; k < LAT; k++) begin
      s_valid = '1;
      #1 chk("flush_ready", s_ready, 0);
      tick();
    end

    // single request on channel 2
    s_din1_re[2*W +: W] = 16'sd3;
    s_din1_im[2*W +: W] = 16'sd4;
    s_din2_re[2*W +: W] = 16'sd5;
    s_din2_im[2*W +: W] = -16'sd2;
    s_valid = 4'b0100;
    #1 chk("single_ready", s_ready, 4'b0100);
    e1.ch = 2; e1.re = 23; e1.im = 14; e1.cyc = cyc + 8;
    expq.push_back(e1);
    tick();
    s_valid = '0;
    chk("issue_valid", m_din_valid, 1);
    chk("issue_din1_re", $signed(m_din1_re), 3);
    chk("issue_din1_im", $signed(m_din1_im), 4);
    chk("issue_din2_re", $signed(m_din2_re), 5);
    chk("issue_din2_im", $signed(m_din2_im), -2);
    tick();
    chk("issue_idle_valid", m_din_valid, 0);
    chk("issue_hold_din1_re", $signed(m_din1_re), 3);
    for (int k = 0; k < 5; k++) tick();
    chk("single_early_valid", dout_valid, 0);
    tick();
    chk("single_dout_valid", dout_valid, 1);
    chk("single_dout_ch", dout_ch, 2);
    chk("single_dout_re", $signed(dout_re), 23);
    chk("single_dout_im", $signed(dout_im), 14);
    tick();
    chk("single_after_valid", dout_valid, 0);

    // arbitration table
    for (int r = 0; r < 16; r++) begin
      set_ops(r);
      s_valid = tbl[r].valid;
      #1;
      checks++;
      if (s_ready !== tbl[r].ready) begin
        errors++;
        $display("FAIL tbl_ready row %0d: got %b expected %b", r, s_ready, tbl[r].ready);
      end
      if (tbl[r].ch >= 0) push_exp(tbl[r].ch, r);
      tick();
    end
    s_valid = '0;
    for (int k = 0; k < 12; k++) tick();

    // full load after a fresh reset
    rst = 1'b1;
    expq.delete();
    tick();
    rst = 1'b0;
    for (int k = 0; k < LAT; k++) tick();
    for (int k = 0; k < 16; k++) begin
      set_ops(20 + k);
      s_valid = '1;
      #1 chk("full_ready", s_ready, 1 << (k % 4));
      push_exp(k % 4, 20 + k);
      tick();
    end
    s_valid = '0;
    for (int k = 0; k < 12; k++) tick();

    // reset while four ops are in flight
    for (int k = 0; k < 4; k++) begin
      set_ops(50 + k);
      s_valid = '1;
      #1 chk("mid_issue_ready", s_ready, 1 << k);
      tick();
    end
    s_valid = '0;
    for (int k = 0; k < 3; k++) tick();
    rst = 1'b1;
    expq.delete();
    tick();
    rst = 1'b0;
    for (int k = 0; k < LAT; k++) begin
      s_valid = '1;
      #1 chk("mid_flush_ready", s_ready, 0);
      tick();
    end
    chk("mid_tag_err", tag_err, 0);
    set_ops(60);
    s_valid = 4'b0010;
    #1 chk("mid_resume_ready", s_ready, 4'b0010);
    push_exp(1, 60);
    tick();
    s_valid = '0;
    for (int k = 0; k < 12; k++) tick();
    chk("mid_tag_err_end", tag_err, 0);

    // spurious multiplier strobe with an empty tag pipe
    inj = 1'b1;
    tick();
    inj = 1'b0;
    chk("inj_tag_err", tag_err, 1);
    chk("inj_dout_valid", dout_valid, 0);
    tick();
    tick();
    chk("inj_tag_err_sticky", tag_err, 1);
    chk("inj_dout_valid_later", dout_valid, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("inj_tag_err_cleared", tag_err, 0);
    tick();

    chk("scoreboard_empty", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
